// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding,
// the default expected truth table and the legal settle-time ceiling.
package sweep_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        HOLD   = ST_HOLD,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_e;

    // X = A & ~(B ^ C), bit i is the output for vector i = {A,B,C}
    localparam logic [7:0] EXPECT_CIRCUIT1_1 = 8'h90;

    localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/settle_timer.sv
// Loadable 4-bit down-counter that times how long a vector is held.
// Ports: clk, rst_n (sync, active-low), load + load_val (reload),
//        en (count down), expire (count has reached 1).
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       expire
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Expiring at 1 makes the last HOLD cycle the one that moves to SAMPLE
    assign expire = (cnt == 4'd1);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks an N_IN-input datapath through every input vector, samples its
// output after SETTLE cycles and checks it against the EXPECT table.
// Ports: clk, rst_n (sync, active-low), start, abort, dut_x (DUT output);
//        vec (DUT stimulus), busy, done, pass, err_count, fail_valid,
//        first_fail_idx.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                  N_IN   = 3,
    parameter int                  SETTLE = 1,
    parameter logic [2**N_IN-1:0]  EXPECT = (2**N_IN)'(EXPECT_CIRCUIT1_1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_x,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("SETTLE out of range");
    end

    localparam logic [3:0]      SETTLE_L = 4'(SETTLE);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_e state;
    state_e state_nxt;

    logic tmr_load;
    logic tmr_en;
    logic tmr_expire;

    logic accept;
    logic kill;
    logic sample;
    logic last;
    logic mismatch;
    logic [N_IN:0] err_nxt;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_L),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        accept    = 1'b0;
        kill      = 1'b0;
        sample    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                tmr_en = 1'b1;
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = IDLE;
                end else if (tmr_expire) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                // abort discards this cycle's comparison
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    sample = 1'b1;
                    if (last) begin
                        state_nxt = DONE;
                    end else begin
                        tmr_load  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign last     = (vec == VEC_LAST);
    // Case inequality so an X or Z on dut_x is a mismatch
    assign mismatch = (dut_x !== EXPECT[vec]);
    assign err_nxt  = err_count + {{N_IN{1'b0}}, mismatch};
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec            <= '0;
            busy           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else if (accept) begin
            vec            <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else if (kill) begin
            vec  <= '0;
            busy <= 1'b0;
            pass <= 1'b0;
        end else if (sample) begin
            err_count <= err_nxt;
            if (mismatch && !fail_valid) begin
                fail_valid     <= 1'b1;
                first_fail_idx <= vec;
            end
            // pass is settled on DONE entry so it is valid alongside done
            if (last) begin
                busy <= 1'b0;
                pass <= (err_nxt == '0);
            end else begin
                vec <= vec + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: two instances (SETTLE 1
// and 3) driven by behavioural gate models, results via a scoreboard.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, abort_a, dut_x_a;
    logic       start_b, abort_b, dut_x_b;
    logic [2:0] vec_a, vec_b;
    logic       busy_a, done_a, pass_a, fv_a;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [3:0] err_a, err_b;
    logic [2:0] ffi_a, ffi_b;
    int         mode;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int err;
        int fv;
        int ffi;
        int pass;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECT(8'h90)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .dut_x(dut_x_a), .vec(vec_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .fail_valid(fv_a),
        .first_fail_idx(ffi_a)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECT(8'h90)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .dut_x(dut_x_b), .vec(vec_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .fail_valid(fv_b),
        .first_fail_idx(ffi_b)
    );

    function automatic logic ref_x(input logic [2:0] v);
        return v[2] & ~(v[1] ^ v[0]);
    endfunction

    // 0: correct gate, 1: stuck-at-0, 2: inverted output
    always_comb begin
        dut_x_a = ref_x(vec_a);
        case (mode)
            1:       dut_x_a = 1'b0;
            2:       dut_x_a = ~ref_x(vec_a);
            default: dut_x_a = ref_x(vec_a);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int m);
        exp_t e;
        int   first;
        logic r, g;
        e.err = 0;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            r = ref_x(3'(i));
            g = (m == 1) ? 1'b0 : (m == 2) ? ~r : r;
            if (g !== r) begin
                e.err++;
                if (first < 0) first = i;
            end
        end
        e.fv   = (e.err > 0) ? 1 : 0;
        e.ffi  = (first < 0) ? 0 : first;
        e.pass = (e.err == 0) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag, input logic [3:0] err,
                             input logic fv, input logic [2:0] ffi,
                             input logic pass);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_err"}, 32'(err), e.err);
            check({tag, "_fv"}, 32'(fv), e.fv);
            check({tag, "_ffi"}, 32'(ffi), e.ffi);
            check({tag, "_pass"}, 32'(pass), e.pass);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_vec"}, 32'(vec_a), 0);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_pass"}, 32'(pass_a), 0);
        check({tag, "_err"}, 32'(err_a), 0);
        check({tag, "_fv"}, 32'(fv_a), 0);
        check({tag, "_ffi"}, 32'(ffi_a), 0);
    endtask

    task automatic run_a(input string tag, input int m);
        int t;
        mode = m;
        push_expect(m);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        t = 0;
        check({tag, "_busy_rise"}, 32'(busy_a), 1);
        while (!done_a && t < 40) begin
            if (t < 16) check({tag, "_vec"}, 32'(vec_a), t / 2);
            tick();
            t++;
        end
        check({tag, "_done_cyc"}, t, 16);
        check({tag, "_busy_at_done"}, 32'(busy_a), 0);
        pop_check(tag, err_a, fv_a, ffi_a, pass_a);
        tick();
        check({tag, "_done_pulse"}, 32'(done_a), 0);
    endtask

    initial begin
        int t;
        int n_done;
        exp_t eb;
        rst_n   = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        dut_x_b = 1'b0;
        mode    = 0;
        repeat (3) tick();
        check_reset_a("rst");
        rst_n = 1'b1;
        tick();

        run_a("good", 0);
        run_a("stuck0", 1);
        run_a("invert", 2);

        // abort lands on the SAMPLE edge of vector 2
        mode    = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        check("abort_vec_held", 32'(vec_a), 2);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_busy", 32'(busy_a), 0);
        check("abort_vec", 32'(vec_a), 0);
        check("abort_pass", 32'(pass_a), 0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_a) n_done++;
            tick();
        end
        check("abort_no_done", n_done, 0);
        run_a("after_abort", 0);

        // inverted DUT so results are non-zero when reset hits
        mode    = 2;
        start_a = 1'b1;
        tick();
        t = 0;
        while (t < 9) begin
            start_a = (t == 3 || t == 6);
            check("rstrun_vec", 32'(vec_a), t / 2);
            if (t == 8) begin
                check("rstrun_err_pre", 32'(err_a), 4);
                rst_n = 1'b0;
            end
            tick();
            t++;
        end
        start_a = 1'b0;
        check_reset_a("midrst");
        rst_n = 1'b1;
        tick();
        run_a("post_rst", 0);

        // SETTLE=3: X during hold, one bad value on vector 5's sample cycle
        eb.err  = 1;
        eb.fv   = 1;
        eb.ffi  = 5;
        eb.pass = 0;
        sb.push_back(eb);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        t = 0;
        while (!done_b && t < 80) begin
            if (t % 4 == 3) begin
                dut_x_b = (t / 4 == 5) ? ~ref_x(3'(t / 4)) : ref_x(3'(t / 4));
            end else begin
                dut_x_b = 1'bx;
            end
            if (t < 32) check("s3_vec", 32'(vec_b), t / 4);
            tick();
            t++;
        end
        check("s3_done_cyc", t, 32);
        check("s3_busy_at_done", 32'(busy_b), 0);
        pop_check("s3", err_b, fv_b, ffi_b, pass_b);
        tick();

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively drives an N-input combinational datapath (default: the 3-input gate circuit, X = A & ~(B ^ C)) through every input vector in ascending binary order. For each vector it samples the single-bit DUT output after a programmable settle time and compares it against a parameterised expected truth table. It accumulates an error count and records the first failing vector. It replaces hand-written per-vector stimulus blocks with one reusable, self-checking controller that sits between a test harness and the datapath under test.

## Interface
- N_IN, 3, number of DUT inputs; sweep length 2^N_IN vectors
- SETTLE, 1, cycles a vector is held before its sample cycle; legal range 1..15
- EXPECT, 8'h90, 2^N_IN-bit expected truth table; bit i = expected X for vector i, where vector i = {A,B,C}
- clk  in  1  sole clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  in  1  request a sweep; accepted only in IDLE
- abort  in  1  cancel a running sweep
- dut_x  in  1  DUT output under test
- vec  out  N_IN  vector driven to the DUT; MSB = A
- busy  out  1  high from start acceptance until DONE is entered
- done  out  1  one-cycle pulse on completion; does not fire on abort
- pass  out  1  high when the last completed sweep had err_count == 0
- err_count  out  N_IN+1  mismatches in the current or last sweep
- fail_valid  out  1  at least one mismatch has been recorded
- first_fail_idx  out  N_IN  index of the first mismatching vector

## Operation
- Reset values: vec = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_valid = 0, first_fail_idx = 0; state = IDLE.
- States and transitions:
  - IDLE: if start = 1, then vec <= 0, cnt <= SETTLE, err_count <= 0, fail_valid <= 0, first_fail_idx <= 0, pass <= 0, busy <= 1, and state <= HOLD.
  - HOLD: cnt decrements each cycle; when cnt == 1, state <= SAMPLE.
  - SAMPLE: compare dut_x against EXPECT[vec] using case-equality. X or Z on dut_x counts as a mismatch.
    - On mismatch: err_count += 1. If fail_valid = 0, then first_fail_idx <= vec and fail_valid <= 1.
    - If vec == 2^N_IN - 1, state <= DONE. Otherwise vec <= vec + 1, cnt <= SETTLE, and state <= HOLD.
  - DONE: done = 1, busy = 0, pass = (err_count == 0); state <= IDLE.
- err_count width N_IN+1 holds the maximum value 2^N_IN, so no saturation logic is required.
- vec stays at its last value in IDLE and DONE. It wraps to 0 only on start.
- Results (pass, err_count, fail_valid, first_fail_idx) hold until the next accepted start or reset.
- abort in HOLD or SAMPLE: state <= IDLE, busy <= 0, vec <= 0, no done pulse, pass <= 0. err_count, fail_valid and first_fail_idx keep their partial values.
- abort in IDLE or DONE has no effect.
- Simultaneous events:
  - abort and a SAMPLE transition in the same cycle: abort wins, and that cycle's comparison is discarded.
  - start while busy: ignored.
  - start and abort together in IDLE: start wins.
  - rst_n low overrides everything, in any state.

## Timing
- Each vector is driven for exactly SETTLE + 1 cycles. dut_x is sampled on the final edge of that window.
- Edge E0 accepts start. The sample for vector i occurs at edge E0 + (i+1)·(SETTLE+1).
- done is high in the cycle following edge E0 + 2^N_IN·(SETTLE+1). For the defaults that is E0 + 16.
- busy rises the cycle after E0 and falls in the same cycle done rises.
- A new start is accepted no earlier than the cycle after done, when the state is back in IDLE.
- Reset mid-sweep: every output returns to its reset value on the first edge with rst_n = 0.

## Structure
- Shared package / header `sweep_pkg`:
  - state encoding localparams: IDLE = 0, HOLD = 1, SAMPLE = 2, DONE = 3
  - EXPECT_CIRCUIT1_1 = 8'h90
  - SETTLE_MAX = 15
- One natural sub-module, `settle_timer`: a loadable 4-bit down-counter with load and expire outputs, instantiated once.
- The FSM, vector counter and scoreboard live in the top module.

## Test plan
- Default DUT (X = A & ~(B^C)), SETTLE = 1, pulse start -> vec steps 0..7 every 2 cycles; done at E0+16; pass = 1; err_count = 0; fail_valid = 0.
- DUT replaced by stuck-at-0 model -> err_count = 2, first_fail_idx = 4, fail_valid = 1, pass = 0.
- DUT replaced by inverted output -> err_count = 8, first_fail_idx = 0, pass = 0; confirms no overflow at 2^N_IN.
- abort asserted at E0+5 (vector 2 held) -> IDLE next edge, busy = 0, vec = 0, no done; a following start runs a clean sweep with pass = 1.
- rst_n low at E0+9 with start re-pulsed during busy -> all outputs at reset values next edge; start pulses during busy never restart the vector sequence.
- SETTLE = 3 -> each vector is held 4 cycles; done at E0+32; dut_x = X during the HOLD cycles is ignored, but X during the SAMPLE cycle counts as one error.
